regfile_sequencer: RTL
======================

Name: regfile_sequencer

Overview:
- Moore-style control FSM that sequences the 8x16 register file, operand registers A/B, shifter/ALU and result register C of the simple RISC datapath.
- Decodes one instruction per start pulse.
- Drives regfile read/write selection and the datapath load enables over several cycles, then returns to waiting.
- Sits between the instruction register and the datapath. The instruction decoder turns `nsel` into `readnum`/`writenum`.

Parameters:
- none; all widths are fixed by the ISA.

Ports:
- `clk`     input   1  rising-edge clock
- `reset`   input   1  asynchronous, active-high reset
- `s`       input   1  start; sampled only in WAIT
- `opcode`  input   3  instruction bits [15:13]
- `op`      input   2  instruction bits [12:11]
- `w`       output  1  1 = idle in WAIT, ready for `s`
- `nsel`    output  3  one-hot register field select: 001 = Rn, 010 = Rd, 100 = Rm, 000 = none
- `vsel`    output  2  regfile write-data mux: 00 = C, 01 = sximm8; 10/11 reserved, never driven
- `write`   output  1  regfile write enable
- `loada`   output  1  load A from regfile `data_out`
- `loadb`   output  1  load B from regfile `data_out`
- `asel`    output  1  1 = force ALU A input to 0
- `bsel`    output  1  1 = B input from sximm5 (held 0 by this block)
- `loadc`   output  1  load C from ALU result
- `loads`   output  1  load status flags

Behaviour:
- **Reset:** state = WAIT. All outputs 0 except `w` = 1. Takes effect immediately on `reset` rising, independent of `clk`. Reset mid-instruction aborts it: no further `write`, no further enable pulses, and captured fields are cleared to 0.
- **Output timing:** outputs are a pure function of current state. Each non-WAIT state lasts exactly one cycle. Every enable not listed for a state is 0.
- **Field capture:** on the WAIT→DECODE edge, `opcode` and `op` are captured into internal registers. Later input changes are ignored until the next WAIT.
- **State outputs:**
  - WAIT: `w` = 1. Go to DECODE when `s` = 1, else stay. `s` is ignored in every other state.
  - DECODE: all outputs 0. Branch on captured fields:
    - 110/10 (MOV imm) → WRITE_IMM
    - 110/00 (MOV reg) → GET_B
    - 101/00 (ADD), 101/01 (CMP), 101/10 (AND) → GET_A
    - 101/11 (MVN) → GET_B
    - anything else → WAIT, with no write and no enables
  - WRITE_IMM: `nsel` = 001, `vsel` = 01, `write` = 1 → WAIT.
  - GET_A: `nsel` = 001, `loada` = 1 → GET_B.
  - GET_B: `nsel` = 100, `loadb` = 1. Next state: 110/00 → SHIFT; 101/01 → CMP; otherwise → ALU.
  - SHIFT: `asel` = 1, `loadc` = 1 → WRITE_REG. A = 0 gives C = shifted B, for ADD-style passthrough.
  - ALU: `loadc` = 1 → WRITE_REG. For MVN, A is ignored by the ALU, so `asel` = 0.
  - CMP: `loads` = 1 → WAIT. C and the regfile are untouched.
  - WRITE_REG: `nsel` = 010, `vsel` = 00, `write` = 1 → WAIT.
- **Cycle counts** (accept edge to `w` high again):
  - MOV imm: 3
  - MOV reg: 5
  - ADD/AND: 6
  - CMP: 5
  - MVN: 5
  - undefined: 2
- **Write-then-read ordering:** `write` is asserted in exactly one state per instruction, at most once, and never together with `loada`/`loadb`. This guarantees a regfile write lands before any later read of the same register.
- **Back-to-back:** `s` held high continuously accepts a new instruction on the first cycle back in WAIT. There are no lost or merged instructions.
- **Encoding:** state encoding is free (binary or one-hot). `nsel` is never multi-hot.

Decomposition:
- **Shared package** `rsm_defs`:
  - opcode constants: `OPC_MOV` = 3'b110, `OPC_ALU` = 3'b101
  - op constants: `OP_ADD`, `OP_CMP`, `OP_AND`, `OP_MVN`, `OP_MOVIMM`, `OP_MOVREG`
  - `nsel` codes: `NSEL_RN` / `NSEL_RD` / `NSEL_RM`
  - `vsel` codes: `VSEL_C` / `VSEL_IMM`
  - state encoding constants
- **Single module.** The next-state logic and output decode stay together. The 5-bit field-capture register stays inline; it needs no sub-module.

Test Plan:
1. Reset: assert `reset` mid-GET_A of an ADD, asynchronously between edges → `w` = 1 and all enables 0 immediately. Next `s` starts a fresh DECODE.
2. MOV imm: `opcode` = 110, `op` = 10, `s` pulse → exactly one `write` cycle with `nsel` = 001, `vsel` = 01, on the 2nd cycle after the accept edge. `w` is back high at cycle 3.
3. ADD, checked in a bench with the regfile (R1 = 3, R2 = 5, ADD R3,R1,R2) → sequence GET_A(`nsel` 001) → GET_B(100) → ALU(`loadc`) → WRITE_REG(010, `vsel` 00). R3 = 8 after 6 cycles.
4. CMP: 101/01 → `loads` pulses once and `write` is never asserted. `w` returns after 5 cycles.
5. Field stability: change `opcode` from 110/10 to 101/01 one cycle after accept → the MOV imm sequence still completes unchanged.
6. Undefined and back-to-back: 111/00 → DECODE → WAIT with no enables (2 cycles). Then hold `s` high across two MOV imm instructions → exactly 2 `write` pulses, 3 cycles apart.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// ============================================================================
//  Module   : rsm_defs (package)
//  Purpose  : Shared ISA field codes, mux select codes, state encoding and
//             control-word layout for the regfile sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rsm_defs;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOVIMM  = 2'b10;
  localparam logic [1:0] OP_MOVREG  = 2'b00;

  localparam logic [2:0] NSEL_NONE  = 3'b000;
  localparam logic [2:0] NSEL_RN    = 3'b001;
  localparam logic [2:0] NSEL_RD    = 3'b010;
  localparam logic [2:0] NSEL_RM    = 3'b100;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;

  typedef enum logic [3:0] {
    S_WAIT      = 4'd0,
    S_DECODE    = 4'd1,
    S_WRITE_IMM = 4'd2,
    S_GET_A     = 4'd3,
    S_GET_B     = 4'd4,
    S_SHIFT     = 4'd5,
    S_ALU       = 4'd6,
    S_CMP       = 4'd7,
    S_WRITE_REG = 4'd8
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{w: 1'b1, nsel: NSEL_NONE, vsel: VSEL_C, default: 1'b0};

  // Moore output decode: the control word belonging to each state.
  function automatic ctrl_t state_ctrl(input state_t st);
    ctrl_t c;
    c = '{nsel: NSEL_NONE, vsel: VSEL_C, default: 1'b0};
    case (st)
      S_WAIT:      c.w = 1'b1;
      S_WRITE_IMM: begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1; end
      S_GET_A:     begin c.nsel = NSEL_RN; c.loada = 1'b1; end
      S_GET_B:     begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
      S_SHIFT:     begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_ALU:       c.loadc = 1'b1;
      S_CMP:       c.loads = 1'b1;
      S_WRITE_REG: begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
      default:     c = c;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
//  Module   : regfile_sequencer
//  Purpose  : Moore control FSM sequencing regfile reads/writes and datapath
//             load enables for one instruction per start pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sequencer
  import rsm_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads
);

  state_t     state_q, state_d;
  logic [2:0] opc_q, opc_d;
  logic [1:0] op_q, op_d;
  ctrl_t      ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    op_d    = op_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          state_d = S_DECODE;
          opc_d   = opcode;
          op_d    = op;
        end
      end
      S_DECODE: begin
        if (opc_q == OPC_MOV && op_q == OP_MOVIMM)      state_d = S_WRITE_IMM;
        else if (opc_q == OPC_MOV && op_q == OP_MOVREG) state_d = S_GET_B;
        else if (opc_q == OPC_ALU)                      state_d = (op_q == OP_MVN) ? S_GET_B : S_GET_A;
        else                                            state_d = S_WAIT;
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B: begin
        if (opc_q == OPC_MOV)     state_d = S_SHIFT;
        else if (op_q == OP_CMP)  state_d = S_CMP;
        else                      state_d = S_ALU;
      end
      S_SHIFT:     state_d = S_WRITE_REG;
      S_ALU:       state_d = S_WRITE_REG;
      S_CMP:       state_d = S_WAIT;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
    // Outputs are registered from the next state so they track the current state exactly.
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      opc_q   <= 3'b000;
      op_q    <= 2'b00;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      op_q    <= op_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign w     = ctrl_q.w;
  assign nsel  = ctrl_q.nsel;
  assign vsel  = ctrl_q.vsel;
  assign write = ctrl_q.write;
  assign loada = ctrl_q.loada;
  assign loadb = ctrl_q.loadb;
  assign asel  = ctrl_q.asel;
  assign bsel  = ctrl_q.bsel;
  assign loadc = ctrl_q.loadc;
  assign loads = ctrl_q.loads;

endmodule

`default_nettype wire
